// File: rtl/seq_mult_w.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_w
// Description : Shift-add sequential multiplier, one multiplier bit per clock.
//               Operands are WIDTH bits, the product is 2*WIDTH bits. Each
//               operation is either unsigned or two's-complement, chosen by
//               sgn when the operation is accepted.
//               Handshake: start is accepted only while busy=0. busy stays
//               high for WIDTH+1 cycles. done pulses for one cycle when p
//               takes the new product. p holds its value between operations.
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous active-high reset
//               start  - operation request (ignored while busy)
//               sgn    - 1 = signed operands, 0 = unsigned (sampled with start)
//               da     - multiplicand (sampled with start)
//               db     - multiplier   (sampled with start)
//               busy   - operation in progress (registered)
//               done   - one-cycle pulse when p is updated (registered)
//               p      - product register, 2*WIDTH bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_w #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     da,
    input  logic [WIDTH-1:0]     db,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int               c_pw   = 2 * WIDTH;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_busy;
    logic              r_done;
    logic [c_pw-1:0]   r_p;
    logic [c_pw-1:0]   r_a;     // multiplicand, pre-shifted by the iteration index
    logic [WIDTH-1:0]  r_b;     // multiplier, shifted right each iteration
    logic [c_pw-1:0]   r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sgn;

    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic              w_iter;
    logic              w_capture;
    logic              w_last;
    logic [c_pw-1:0]   w_addend;
    logic [c_pw-1:0]   w_acc_nxt;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_iter      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_busy_nxt  = 1'b1;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                w_iter = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_capture   = 1'b1;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_last   = (r_cnt == c_last);
    assign w_addend = r_b[0] ? r_a : '0;

    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so the
    // final partial product is subtracted instead of added.
    assign w_acc_nxt = (r_sgn && w_last) ? (r_acc - w_addend)
                                         : (r_acc + w_addend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_p    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sgn  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_a   <= sgn ? {{WIDTH{da[WIDTH-1]}}, da} : {{WIDTH{1'b0}}, da};
                r_b   <= db;
                r_sgn <= sgn;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_iter) begin
                r_acc <= w_acc_nxt;
                r_a   <= r_a << 1;
                r_b   <= {1'b0, r_b[WIDTH-1:1]};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_p <= r_acc;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_w.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_w
// Description : Directed self-checking bench for seq_mult_w. One instance at
//               WIDTH=4 and one at WIDTH=8 share clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_w;

    logic        clk;
    logic        reset;

    logic        start4, sgn4;
    logic [3:0]  da4, db4;
    logic        busy4, done4;
    logic [7:0]  p4;

    logic        start8, sgn8;
    logic [7:0]  da8, db8;
    logic        busy8, done8;
    logic [15:0] p8;

    int total;
    int bad;

    seq_mult_w #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .sgn   (sgn4),
        .da    (da4),
        .db    (db4),
        .busy  (busy4),
        .done  (done4),
        .p     (p4)
    );

    seq_mult_w #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .sgn   (sgn8),
        .da    (da8),
        .db    (db8),
        .busy  (busy8),
        .done  (done8),
        .p     (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run one operation on the selected instance and check latency, busy
    // length, product, and (optionally) that done drops after one cycle.
    // b2b=1 means the call starts right in the done cycle of the previous op.
    task automatic op(input int w, input logic s, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp,
                      input string tag, input bit b2b, input bit chkfall);
        int n;
        int busy_cnt;
        bit seen;
        bit held;
        logic [15:0] p_before;
        if (!b2b) @(negedge clk);
        if (w == 4) begin
            sgn4 = s; da4 = a[3:0]; db4 = b[3:0]; start4 = 1'b1;
        end else begin
            sgn8 = s; da8 = a; db8 = b; start8 = 1'b1;
        end
        @(posedge clk); #1;
        // scramble operands during RUN; they must have no effect
        if (w == 4) begin
            start4 = 1'b0; sgn4 = ~s; da4 = ~a[3:0]; db4 = ~b[3:0];
            p_before = {8'h00, p4};
            chk({tag, "_busy_on"}, {63'd0, busy4}, 64'd1);
        end else begin
            start8 = 1'b0; sgn8 = ~s; da8 = ~a; db8 = ~b;
            p_before = p8;
            chk({tag, "_busy_on"}, {63'd0, busy8}, 64'd1);
        end
        n = 0; busy_cnt = 0; seen = 1'b0; held = 1'b1;
        while (!seen && n < 40) begin
            if ((w == 4) ? busy4 : busy8) busy_cnt++;
            if (((w == 4) ? {8'h00, p4} : p8) !== p_before) held = 1'b0;
            @(posedge clk); #1;
            n++;
            if ((w == 4) ? done4 : done8) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        chk({tag, "_latency"}, 64'(n), 64'(w + 1));
        chk({tag, "_busy_len"}, 64'(busy_cnt), 64'(w + 1));
        chk({tag, "_p_held"}, {63'd0, held}, 64'd1);
        chk({tag, "_p"}, (w == 4) ? {56'd0, p4} : {48'd0, p8}, {48'd0, exp});
        chk({tag, "_busy_off"}, {63'd0, (w == 4) ? busy4 : busy8}, 64'd0);
        if (chkfall) begin
            @(posedge clk); #1;
            chk({tag, "_done_fall"}, {63'd0, (w == 4) ? done4 : done8}, 64'd0);
        end
    endtask

    initial begin
        int n;
        int dones;
        bit any_done;
        bit busy_gap;
        total = 0; bad = 0;
        reset = 1'b1;
        start4 = 1'b0; sgn4 = 1'b0; da4 = '0; db4 = '0;
        start8 = 1'b0; sgn8 = 1'b0; da8 = '0; db8 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy4", {63'd0, busy4}, 64'd0);
        chk("rst_done4", {63'd0, done4}, 64'd0);
        chk("rst_p4", {56'd0, p4}, 64'd0);
        chk("rst_busy8", {63'd0, busy8}, 64'd0);
        chk("rst_p8", {48'd0, p8}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // unsigned and signed products, WIDTH=4
        op(4, 1'b0, 8'd15, 8'd15, 16'h00E1, "u15x15", 1'b0, 1'b1);
        op(4, 1'b1, 8'h08, 8'h08, 16'h0040, "sm8xm8", 1'b0, 1'b1);
        op(4, 1'b1, 8'h08, 8'h07, 16'h00C8, "sm8x7", 1'b0, 1'b1);
        op(4, 1'b1, 8'h03, 8'h0F, 16'h00FD, "s3xm1", 1'b0, 1'b1);

        // back-to-back: second start issued in the done cycle of the first
        op(4, 1'b0, 8'd9, 8'd0, 16'h0000, "u9x0", 1'b0, 1'b0);
        op(4, 1'b0, 8'd0, 8'd9, 16'h0000, "b2b_0x9", 1'b1, 1'b1);

        // WIDTH=8
        op(8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "u255x255", 1'b0, 1'b1);
        op(8, 1'b1, 8'h80, 8'h80, 16'h4000, "s80x80", 1'b0, 1'b1);

        // start held high while busy must not queue a second operation
        @(negedge clk);
        sgn4 = 1'b0; da4 = 4'd5; db4 = 4'd3; start4 = 1'b1;
        @(posedge clk); #1;
        da4 = 4'd7; db4 = 4'd7;
        n = 0; dones = 0; busy_gap = 1'b0;
        while (dones == 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done4) dones++;
            else if (!busy4) busy_gap = 1'b1;
        end
        start4 = 1'b0;
        chk("hold_latency", 64'(n), 64'd5);
        chk("hold_p", {56'd0, p4}, 64'd15);
        chk("hold_no_reaccept", {63'd0, busy_gap}, 64'd0);
        repeat (8) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        chk("hold_one_done", 64'(dones), 64'd1);
        chk("hold_idle", {63'd0, busy4}, 64'd0);

        // asynchronous reset two clocks into RUN aborts the operation
        @(negedge clk);
        sgn4 = 1'b0; da4 = 4'd15; db4 = 4'd15; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy4}, 64'd0);
        chk("arst_done", {63'd0, done4}, 64'd0);
        chk("arst_p", {56'd0, p4}, 64'd0);
        chk("arst_p8", {48'd0, p8}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        any_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done4) any_done = 1'b1;
        end
        chk("arst_no_done", {63'd0, any_done}, 64'd0);
        op(4, 1'b0, 8'd6, 8'd6, 16'h0024, "post_rst_6x6", 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
